// File: rtl/hazard_irq_ctrl_if.sv
// Pipeline-control bundle between the MIPS datapath and hazard_irq_ctrl.
// slave = controller side, master = datapath side.
interface hazard_irq_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             irq_req;
   logic             irq_en;
   logic             kernel_mode;
   logic             id_valid;
   logic [31:0]      id_pcplus4;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rs;
   logic             id_uses_rt;
   logic             id_jump;
   logic             ex_memread;
   logic [4:0]       ex_rt;
   logic             ex_branch_taken;
   logic             pc_we;
   logic [1:0]       pc_src;
   logic             ifid_we;
   logic             ifid_flush;
   logic             idex_flush;
   logic [31:0]      epc;
   logic             epc_we;
   logic             irq_ack;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   // Vector the PC mux loads when pc_src selects the interrupt entry
   logic [31:0]      irq_vector;

   modport slave (
      input  irq_req, irq_en, kernel_mode, id_valid, id_pcplus4,
             id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump,
             ex_memread, ex_rt, ex_branch_taken,
      output pc_we, pc_src, ifid_we, ifid_flush, idex_flush,
             epc, epc_we, irq_ack, stall_cnt, flush_cnt, irq_vector
   );

   modport master (
      output irq_req, irq_en, kernel_mode, id_valid, id_pcplus4,
             id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump,
             ex_memread, ex_rt, ex_branch_taken,
      input  pc_we, pc_src, ifid_we, ifid_flush, idex_flush,
             epc, epc_we, irq_ack, stall_cnt, flush_cnt, irq_vector
   );
endinterface

// File: rtl/hazard_irq_ctrl.sv
// Hazard / redirect / interrupt-entry sequencer for the 5-stage MIPS pipeline,
// with stall and flush performance counters.
module hazard_irq_ctrl #(
   parameter int          CNT_W      = 16,
   parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004
) (
   input logic              clk,
   input logic              reset,
   hazard_irq_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      RUN   = 2'b00,
      DRAIN = 2'b01,
      TAKE  = 2'b10
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [31:0]      epc_r;
   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] flush_cnt_r;

   logic             load_use_s;
   logic             stall_s;
   logic             pc_we_s;
   logic [1:0]       pc_src_s;
   logic             ifid_we_s;
   logic             ifid_flush_s;
   logic             idex_flush_s;
   logic             epc_we_s;
   logic             irq_ack_s;

   assign load_use_s = bus.ex_memread && (bus.ex_rt != 5'd0) &&
                       ((bus.id_uses_rs && (bus.id_rs == bus.ex_rt)) ||
                        (bus.id_uses_rt && (bus.id_rt == bus.ex_rt)));

   // Next-state and pipeline control decode
   always_comb begin
      state_nxt_s  = state_r;
      pc_we_s      = 1'b1;
      pc_src_s     = 2'b00;
      ifid_we_s    = 1'b1;
      ifid_flush_s = 1'b0;
      idex_flush_s = 1'b0;
      epc_we_s     = 1'b0;
      irq_ack_s    = 1'b0;
      stall_s      = 1'b0;
      if (reset) begin
         state_nxt_s = RUN;
      end else begin
         case (state_r)
            RUN, DRAIN: begin
               if (bus.ex_branch_taken) begin
                  pc_src_s     = 2'b01;
                  ifid_flush_s = 1'b1;
                  idex_flush_s = 1'b1;
               end else if (load_use_s) begin
                  // A jump held behind a load-use is re-decoded next cycle
                  pc_we_s      = 1'b0;
                  ifid_we_s    = 1'b0;
                  idex_flush_s = 1'b1;
                  stall_s      = 1'b1;
               end else if (bus.id_jump) begin
                  pc_src_s     = 2'b10;
                  ifid_flush_s = 1'b1;
               end else begin
                  pc_src_s     = 2'b00;
               end

               if (state_r == RUN) begin
                  if (bus.irq_req && bus.irq_en && !bus.kernel_mode) begin
                     state_nxt_s = DRAIN;
                  end else begin
                     state_nxt_s = RUN;
                  end
               end else if (!(bus.irq_req && bus.irq_en)) begin
                  state_nxt_s = RUN;
               end else if (bus.id_valid && !bus.ex_branch_taken &&
                            !load_use_s && !bus.id_jump) begin
                  state_nxt_s = TAKE;
               end else begin
                  state_nxt_s = DRAIN;
               end
            end
            TAKE: begin
               pc_src_s     = 2'b11;
               pc_we_s      = 1'b1;
               ifid_flush_s = 1'b1;
               idex_flush_s = 1'b1;
               epc_we_s     = 1'b1;
               irq_ack_s    = 1'b1;
               state_nxt_s  = RUN;
            end
            default: begin
               state_nxt_s = RUN;
            end
         endcase
      end
   end

   // State, exception PC capture and performance counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= RUN;
         epc_r       <= 32'd0;
         stall_cnt_r <= '0;
         flush_cnt_r <= '0;
      end else begin
         state_r <= state_nxt_s;
         // The ID instruction is squashed by TAKE, so return re-executes it
         if ((state_r == DRAIN) && (state_nxt_s == TAKE)) begin
            epc_r <= bus.id_pcplus4 - 32'd4;
         end
         if (stall_s) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
         end
         if (ifid_flush_s) begin
            flush_cnt_r <= flush_cnt_r + CNT_W'(1);
         end
      end
   end

   assign bus.pc_we      = pc_we_s;
   assign bus.pc_src     = pc_src_s;
   assign bus.ifid_we    = ifid_we_s;
   assign bus.ifid_flush = ifid_flush_s;
   assign bus.idex_flush = idex_flush_s;
   assign bus.epc        = epc_r;
   assign bus.epc_we     = epc_we_s;
   assign bus.irq_ack    = irq_ack_s;
   assign bus.stall_cnt  = stall_cnt_r;
   assign bus.flush_cnt  = flush_cnt_r;
   assign bus.irq_vector = IRQ_VECTOR;
endmodule

// File: tb/tb_hazard_irq_ctrl.sv
// Directed self-checking bench for hazard_irq_ctrl.
module tb_hazard_irq_ctrl;
   logic clk;
   logic reset;
   int   tests;
   int   failed;

   hazard_irq_ctrl_if #(.CNT_W(16)) bus ();

   hazard_irq_ctrl #(.CNT_W(16), .IRQ_VECTOR(32'h8000_0004)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      reset  = 1'b1;
      bus.irq_req = 1'b0;     bus.irq_en = 1'b0;      bus.kernel_mode = 1'b0;
      bus.id_valid = 1'b0;    bus.id_pcplus4 = 32'd0; bus.id_rs = 5'd0;
      bus.id_rt = 5'd0;       bus.id_uses_rs = 1'b0;  bus.id_uses_rt = 1'b0;
      bus.id_jump = 1'b0;     bus.ex_memread = 1'b0;  bus.ex_rt = 5'd0;
      bus.ex_branch_taken = 1'b0;

      // Reset: registers clear, control outputs stay at defaults even with a branch
      repeat (2) @(posedge clk);
      #1;
      bus.ex_branch_taken = 1'b1;
      #1;
      check("rst_ifid_flush", {31'd0, bus.ifid_flush}, 32'd0);
      check("rst_idex_flush", {31'd0, bus.idex_flush}, 32'd0);
      check("rst_pc_src", {30'd0, bus.pc_src}, 32'd0);
      check("rst_pc_we", {31'd0, bus.pc_we}, 32'd1);
      check("rst_ifid_we", {31'd0, bus.ifid_we}, 32'd1);
      check("rst_epc", bus.epc, 32'd0);
      check("rst_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
      check("rst_flush_cnt", {16'd0, bus.flush_cnt}, 32'd0);
      check("rst_irq_ack", {31'd0, bus.irq_ack}, 32'd0);
      bus.ex_branch_taken = 1'b0;
      reset = 1'b0;
      tick();

      // Load-use on rs
      bus.id_valid = 1'b1; bus.ex_memread = 1'b1; bus.ex_rt = 5'd2;
      bus.id_uses_rs = 1'b1; bus.id_rs = 5'd2;
      #1;
      check("lu_pc_we", {31'd0, bus.pc_we}, 32'd0);
      check("lu_ifid_we", {31'd0, bus.ifid_we}, 32'd0);
      check("lu_idex_flush", {31'd0, bus.idex_flush}, 32'd1);
      check("lu_ifid_flush", {31'd0, bus.ifid_flush}, 32'd0);
      tick();
      check("lu_stall_cnt", {16'd0, bus.stall_cnt}, 32'd1);

      // Load into $0 never stalls
      bus.ex_rt = 5'd0; bus.id_rs = 5'd0;
      #1;
      check("r0_pc_we", {31'd0, bus.pc_we}, 32'd1);
      check("r0_idex_flush", {31'd0, bus.idex_flush}, 32'd0);
      tick();
      check("r0_stall_cnt", {16'd0, bus.stall_cnt}, 32'd1);

      // Load-use on rt only; rs match without use must not count
      bus.id_uses_rs = 1'b0; bus.id_rs = 5'd7; bus.id_uses_rt = 1'b1;
      bus.id_rt = 5'd7; bus.ex_rt = 5'd7;
      #1;
      check("rt_pc_we", {31'd0, bus.pc_we}, 32'd0);
      check("rt_ifid_we", {31'd0, bus.ifid_we}, 32'd0);
      tick();
      check("rt_stall_cnt", {16'd0, bus.stall_cnt}, 32'd2);
      bus.id_uses_rt = 1'b0;
      #1;
      check("nouse_pc_we", {31'd0, bus.pc_we}, 32'd1);

      // Taken branch beats load-use
      bus.id_uses_rt = 1'b1; bus.ex_branch_taken = 1'b1;
      #1;
      check("br_pc_src", {30'd0, bus.pc_src}, 32'd1);
      check("br_ifid_flush", {31'd0, bus.ifid_flush}, 32'd1);
      check("br_idex_flush", {31'd0, bus.idex_flush}, 32'd1);
      check("br_pc_we", {31'd0, bus.pc_we}, 32'd1);
      check("br_ifid_we", {31'd0, bus.ifid_we}, 32'd1);
      tick();
      check("br_stall_cnt", {16'd0, bus.stall_cnt}, 32'd2);
      check("br_flush_cnt", {16'd0, bus.flush_cnt}, 32'd1);

      // Jump held behind load-use, then redirected
      bus.ex_branch_taken = 1'b0; bus.id_jump = 1'b1;
      #1;
      check("jlu_pc_src", {30'd0, bus.pc_src}, 32'd0);
      check("jlu_pc_we", {31'd0, bus.pc_we}, 32'd0);
      check("jlu_ifid_flush", {31'd0, bus.ifid_flush}, 32'd0);
      tick();
      check("jlu_stall_cnt", {16'd0, bus.stall_cnt}, 32'd3);
      bus.ex_memread = 1'b0;
      #1;
      check("j_pc_src", {30'd0, bus.pc_src}, 32'd2);
      check("j_ifid_flush", {31'd0, bus.ifid_flush}, 32'd1);
      check("j_idex_flush", {31'd0, bus.idex_flush}, 32'd0);
      check("j_pc_we", {31'd0, bus.pc_we}, 32'd1);
      tick();
      check("j_flush_cnt", {16'd0, bus.flush_cnt}, 32'd2);
      bus.id_jump = 1'b0; bus.id_uses_rt = 1'b0;

      // Interrupt entry with no hazards
      bus.id_pcplus4 = 32'h0000_0040; bus.irq_en = 1'b1; bus.irq_req = 1'b1;
      #1;
      check("irq_run_ack", {31'd0, bus.irq_ack}, 32'd0);
      tick();
      check("irq_drain_ack", {31'd0, bus.irq_ack}, 32'd0);
      check("irq_drain_pc_src", {30'd0, bus.pc_src}, 32'd0);
      check("irq_drain_epc_we", {31'd0, bus.epc_we}, 32'd0);
      tick();
      check("take_pc_src", {30'd0, bus.pc_src}, 32'd3);
      check("take_irq_ack", {31'd0, bus.irq_ack}, 32'd1);
      check("take_epc_we", {31'd0, bus.epc_we}, 32'd1);
      check("take_ifid_flush", {31'd0, bus.ifid_flush}, 32'd1);
      check("take_idex_flush", {31'd0, bus.idex_flush}, 32'd1);
      check("take_pc_we", {31'd0, bus.pc_we}, 32'd1);
      check("take_epc", bus.epc, 32'h0000_003C);
      check("take_vector", bus.irq_vector, 32'h8000_0004);
      tick();
      bus.kernel_mode = 1'b1;
      #1;
      check("post_take_ack", {31'd0, bus.irq_ack}, 32'd0);
      check("post_take_epc_we", {31'd0, bus.epc_we}, 32'd0);
      check("post_take_flush_cnt", {16'd0, bus.flush_cnt}, 32'd3);
      tick();
      check("kern_ack_1", {31'd0, bus.irq_ack}, 32'd0);
      tick();
      check("kern_ack_2", {31'd0, bus.irq_ack}, 32'd0);
      check("kern_epc_hold", bus.epc, 32'h0000_003C);

      // Interrupt waits in DRAIN while ID holds a bubble
      bus.kernel_mode = 1'b0; bus.id_valid = 1'b0; bus.id_pcplus4 = 32'h0000_0100;
      tick();
      for (int i = 0; i < 3; i++) begin
         check("bubble_drain_ack", {31'd0, bus.irq_ack}, 32'd0);
         tick();
      end
      check("bubble_drain4_ack", {31'd0, bus.irq_ack}, 32'd0);
      bus.id_valid = 1'b1;
      #1;
      check("bubble_valid_ack", {31'd0, bus.irq_ack}, 32'd0);
      tick();
      check("bubble_take_ack", {31'd0, bus.irq_ack}, 32'd1);
      check("bubble_take_epc", bus.epc, 32'h0000_00FC);
      bus.irq_req = 1'b0;
      tick();
      check("bubble_post_ack", {31'd0, bus.irq_ack}, 32'd0);
      check("bubble_flush_cnt", {16'd0, bus.flush_cnt}, 32'd4);
      check("bubble_epc_hold", bus.epc, 32'h0000_00FC);

      // Request withdrawn during DRAIN: back to RUN, no ack
      bus.irq_req = 1'b1; bus.id_valid = 1'b0;
      tick();
      bus.irq_req = 1'b0; bus.id_valid = 1'b1;
      tick();
      check("drop_ack_1", {31'd0, bus.irq_ack}, 32'd0);
      tick();
      check("drop_ack_2", {31'd0, bus.irq_ack}, 32'd0);

      // Reset asserted mid-DRAIN
      bus.irq_req = 1'b1; bus.id_valid = 1'b0; bus.id_pcplus4 = 32'h0000_0200;
      tick();
      reset = 1'b1;
      #1;
      check("mrst_epc", bus.epc, 32'd0);
      check("mrst_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
      check("mrst_flush_cnt", {16'd0, bus.flush_cnt}, 32'd0);
      check("mrst_ack", {31'd0, bus.irq_ack}, 32'd0);
      check("mrst_pc_we", {31'd0, bus.pc_we}, 32'd1);
      bus.id_valid = 1'b1;
      tick();
      check("mrst_hold_ack", {31'd0, bus.irq_ack}, 32'd0);
      reset = 1'b0;
      #1;
      check("mrst_rel_ack", {31'd0, bus.irq_ack}, 32'd0);
      tick();
      check("mrst_drain_ack", {31'd0, bus.irq_ack}, 32'd0);
      tick();
      check("mrst_take_ack", {31'd0, bus.irq_ack}, 32'd1);
      check("mrst_take_epc", bus.epc, 32'h0000_01FC);
      bus.irq_req = 1'b0;
      tick();
      check("mrst_post_ack", {31'd0, bus.irq_ack}, 32'd0);
      check("mrst_flush_cnt_after", {16'd0, bus.flush_cnt}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
